// File: rtl/dense_pkg.sv
// Shared types and helpers for the dense-layer accumulator: FSM state
// encoding and the accumulator width rule.
package dense_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } dense_state_t;

  // Product width plus growth for M additions plus one guard bit.
  function automatic int acc_width(input int width, input int m);
    return 2 * width + $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/dense_round_sat.sv
// One output lane: bias add, round-half-up, arithmetic shift by FRAC, then
// narrow to WIDTH (clamp when DENSE_SAT_EN is defined, wrap otherwise).
module dense_round_sat #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int ACC_W = 36
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [WIDTH-1:0] bias,
  output logic [WIDTH-1:0] res,
  output logic             sat
);

  // One extra bit so the bias and rounding adds can never wrap.
  localparam int SW = ACC_W + 1;

  logic signed [SW-1:0] acc_s;
  logic signed [SW-1:0] bias_s;
  logic signed [SW-1:0] half_s;
  logic signed [SW-1:0] sum_s;
  logic signed [SW-1:0] r_s;

  assign acc_s  = {acc[ACC_W-1], acc};
  assign bias_s = {{(SW-WIDTH){bias[WIDTH-1]}}, bias} << FRAC;
  assign half_s = {{(SW-1){1'b0}}, 1'b1} << (FRAC - 1);
  assign sum_s  = acc_s + bias_s + half_s;
  assign r_s    = sum_s >>> FRAC;

`ifdef DENSE_SAT_EN
  localparam logic signed [SW-1:0] MAXV = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  // Clamp to the signed WIDTH range and flag when clamping happened.
  always_comb begin
    res = r_s[WIDTH-1:0];
    sat = 1'b0;
    if (r_s > MAXV) begin
      res = MAXV[WIDTH-1:0];
      sat = 1'b1;
    end else if (r_s < MINV) begin
      res = MINV[WIDTH-1:0];
      sat = 1'b1;
    end else begin
      res = r_s[WIDTH-1:0];
      sat = 1'b0;
    end
  end
`else
  logic unused_s;

  assign res      = r_s[WIDTH-1:0];
  assign sat      = 1'b0;
  assign unused_s = ^r_s[SW-1:WIDTH];
`endif

endmodule

// File: rtl/dense_accum.sv
// Dense-layer MAC accumulator feeding relu: N lanes, M beats per frame.
// Optional output clamping is enabled by defining DENSE_SAT_EN.
module dense_accum
  import dense_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int M     = 8,
  parameter int FRAC  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [N*WIDTH-1:0]   w_col,
  input  logic [N*WIDTH-1:0]   bias,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WIDTH-1:0]   out_vec,
  output logic [N-1:0]         sat_flag
);

  localparam int ACC_W = acc_width(WIDTH, M);
  localparam int KW    = (M > 1) ? $clog2(M) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(M - 1);

  dense_state_t state_r, state_s;
  logic [KW-1:0] k_r;
  logic accept_s;
  logic last_s;

  logic signed [ACC_W-1:0]   acc_r  [N];
  logic signed [2*WIDTH-1:0] prod_s [N];
  logic signed [ACC_W-1:0]   pext_s [N];
  logic [WIDTH-1:0]          res_s  [N];
  logic [N-1:0]              sat_s;
  logic [N*WIDTH-1:0]        out_vec_r;
  logic [N-1:0]              sat_r;

  assign in_ready  = (state_r == ACCUM);
  assign out_valid = (state_r == OUT);
  assign accept_s  = in_valid && in_ready;
  assign last_s    = accept_s && (k_r == K_LAST);
  assign out_vec   = out_vec_r;
  assign sat_flag  = sat_r;

  // Next-state decode for the frame sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:  state_s = ACCUM;
      ACCUM: begin
        if (last_s) state_s = ROUND;
        else        state_s = ACCUM;
      end
      ROUND: state_s = OUT;
      OUT: begin
        if (out_ready) state_s = ACCUM;
        else           state_s = OUT;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Full-width signed products, sign-extended to the accumulator width.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      prod_s[j] = {{WIDTH{in_data[WIDTH-1]}}, in_data} *
                  {{WIDTH{w_col[j*WIDTH+WIDTH-1]}}, w_col[j*WIDTH +: WIDTH]};
      pext_s[j] = {{(ACC_W-2*WIDTH){prod_s[j][2*WIDTH-1]}}, prod_s[j]};
    end
  end

  // Accumulators and beat counter; both clear in ROUND once consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_r <= '0;
      for (int j = 0; j < N; j++) acc_r[j] <= '0;
    end else if (accept_s) begin
      k_r <= k_r + KW'(1'b1);
      for (int j = 0; j < N; j++) acc_r[j] <= acc_r[j] + pext_s[j];
    end else if (state_r == ROUND) begin
      k_r <= '0;
      for (int j = 0; j < N; j++) acc_r[j] <= '0;
    end else begin
      k_r <= k_r;
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_lane
    dense_round_sat #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC),
      .ACC_W (ACC_W)
    ) u_round (
      .acc  (acc_r[j]),
      .bias (bias[j*WIDTH +: WIDTH]),
      .res  (res_s[j]),
      .sat  (sat_s[j])
    );
  end

  // Result registers load in ROUND and hold through OUT and the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vec_r <= '0;
      sat_r     <= '0;
    end else if (state_r == ROUND) begin
      for (int j = 0; j < N; j++) out_vec_r[j*WIDTH +: WIDTH] <= res_s[j];
      sat_r <= sat_s;
    end else begin
      out_vec_r <= out_vec_r;
      sat_r     <= sat_r;
    end
  end

endmodule
